// File: rtl/pic_pkg.sv
// Shared constants, FSM encoding and priority helper for the PIC request/priority stage.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned LVL_W  = 3;

  // Level reported when INTA arrives with nothing pending.
  localparam logic [LVL_W-1:0] SPUR_LVL = 3'd7;

  typedef enum logic [0:0] {StIdle, StWait2} pic_state_e;

  // Rank 0 is the highest-priority level; with low_pri = 7 the rank equals the level.
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                  input logic [LVL_W-1:0] low_pri);
    logic [LVL_W-1:0] top;
    top = low_pri + 3'd1;
    return lvl - top;
  endfunction

endpackage

// File: rtl/pic_prio_encoder.sv
// Combinational 8-to-3 highest-priority encoder; level low_pri_i+1 (mod 8) ranks first.
module pic_prio_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req_i,
  input  logic [LVL_W-1:0]  low_pri_i,
  output logic [LVL_W-1:0]  lvl_o,
  output logic              valid_o
);

  logic [LVL_W-1:0] idx;

  always_comb begin
    lvl_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      idx = low_pri_i + 3'd1 + LVL_W'(i);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        lvl_o   = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_core.sv
// PIC request capture, masking, priority resolution and two-pulse INTA handshake.
// Optional rotating priority is enabled by defining PIC_ROTATE_PRIORITY_EN.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir_i,
  input  logic [NUM_IR-1:0] imr_i,
  input  logic              ltim_i,
  input  logic              aeoi_i,
  input  logic              inta_n_i,
  input  logic              eoi_ns_i,
  input  logic              eoi_sp_i,
  input  logic [LVL_W-1:0]  eoi_level_i,
`ifdef PIC_ROTATE_PRIORITY_EN
  input  logic              rotate_i,
`endif
  output logic              int_req_o,
  output logic [NUM_IR-1:0] irr_o,
  output logic [NUM_IR-1:0] isr_o,
  output logic [LVL_W-1:0]  vec_level_o,
  output logic              vec_valid_o,
  output logic              spurious_o
);

  logic [SYNC_STAGES-1:0][NUM_IR-1:0] ir_sync_q;
  logic [SYNC_STAGES-1:0]             inta_sync_q;
  logic [NUM_IR-1:0]                  ir_prev_q;
  logic                               inta_prev_q;
  logic [NUM_IR-1:0]                  ir_s;
  logic                               inta_s;

  pic_state_e        state_q, state_d;
  logic [NUM_IR-1:0] irr_q, irr_d, isr_q, isr_d;
  logic [LVL_W-1:0]  ack_lvl_q, ack_lvl_d, vec_level_q, vec_level_d;
  logic              spur_q, spur_d, int_req_q, int_req_d;
  logic              vec_valid_q, vec_valid_d, spurious_q, spurious_d;

  logic [NUM_IR-1:0] pending, rise, inta_set, eoi_clr, irr_clr;
  logic [LVL_W-1:0]  req_lvl, cur_lvl, low_pri;
  logic              req_vld, cur_vld, inta_fall, ack1, ack2, want_int;

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [LVL_W-1:0] low_pri_q, low_pri_d;
  assign low_pri = low_pri_q;
`else
  assign low_pri = SPUR_LVL;
`endif

  assign ir_s      = ir_sync_q[SYNC_STAGES-1];
  assign inta_s    = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign ack1      = (state_q == StIdle) && inta_fall;
  assign ack2      = (state_q == StWait2) && inta_fall;
  assign pending   = irr_q & ~imr_i;
  assign rise      = ir_s & ~ir_prev_q;

  pic_prio_encoder u_req_enc (
    .req_i     (pending),
    .low_pri_i (low_pri),
    .lvl_o     (req_lvl),
    .valid_o   (req_vld)
  );

  pic_prio_encoder u_cur_enc (
    .req_i     (isr_q),
    .low_pri_i (low_pri),
    .lvl_o     (cur_lvl),
    .valid_o   (cur_vld)
  );

  assign want_int = req_vld &&
                    (!cur_vld || (prio_rank(req_lvl, low_pri) < prio_rank(cur_lvl, low_pri)));

  always_comb begin
    state_d     = state_q;
    ack_lvl_d   = ack_lvl_q;
    spur_d      = spur_q;
    vec_level_d = vec_level_q;
    vec_valid_d = 1'b0;
    spurious_d  = 1'b0;
    inta_set    = '0;
    eoi_clr     = '0;
    irr_clr     = '0;
`ifdef PIC_ROTATE_PRIORITY_EN
    low_pri_d   = low_pri_q;
`endif

    if (ack1) begin
      state_d = StWait2;
      if (req_vld) begin
        ack_lvl_d         = req_lvl;
        spur_d            = 1'b0;
        inta_set[req_lvl] = 1'b1;
        irr_clr[req_lvl]  = 1'b1;
      end else begin
        ack_lvl_d = SPUR_LVL;
        spur_d    = 1'b1;
      end
    end

    if (eoi_sp_i) begin
      eoi_clr[eoi_level_i] = 1'b1;
    end else if (eoi_ns_i && cur_vld) begin
      eoi_clr[cur_lvl] = 1'b1;
`ifdef PIC_ROTATE_PRIORITY_EN
      if (rotate_i) low_pri_d = cur_lvl;
`endif
    end

    if (ack2) begin
      state_d     = StIdle;
      vec_level_d = ack_lvl_q;
      vec_valid_d = 1'b1;
      spurious_d  = spur_q;
      if (aeoi_i && !spur_q) begin
        eoi_clr[ack_lvl_q] = 1'b1;
`ifdef PIC_ROTATE_PRIORITY_EN
        if (rotate_i) low_pri_d = ack_lvl_q;
`endif
      end
    end

    // An INTA set outranks an EOI clear on the same bit.
    isr_d = (isr_q & ~eoi_clr) | inta_set;

    if (ltim_i) begin
      irr_d = ir_s & ~irr_clr;
    end else begin
      irr_d = (irr_q | rise) & ~irr_clr;
      // An edge request withdrawn before acknowledge is forgotten.
      if (state_q == StIdle) irr_d = irr_d & ir_s;
    end

    int_req_d = (state_q == StIdle) && !inta_fall && want_int;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sync_q   <= '0;
      inta_sync_q <= '1;
      ir_prev_q   <= '0;
      inta_prev_q <= 1'b1;
      state_q     <= StIdle;
      irr_q       <= '0;
      isr_q       <= '0;
      ack_lvl_q   <= '0;
      spur_q      <= 1'b0;
      int_req_q   <= 1'b0;
      vec_level_q <= '0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
      low_pri_q   <= SPUR_LVL;
`endif
    end else begin
      ir_sync_q   <= {ir_sync_q[SYNC_STAGES-2:0], ir_i};
      inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], inta_n_i};
      ir_prev_q   <= ir_s;
      inta_prev_q <= inta_s;
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ack_lvl_q   <= ack_lvl_d;
      spur_q      <= spur_d;
      int_req_q   <= int_req_d;
      vec_level_q <= vec_level_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
`ifdef PIC_ROTATE_PRIORITY_EN
      low_pri_q   <= low_pri_d;
`endif
    end
  end

  assign int_req_o   = int_req_q;
  assign irr_o       = irr_q;
  assign isr_o       = isr_q;
  assign vec_level_o = vec_level_q;
  assign vec_valid_o = vec_valid_q;
  assign spurious_o  = spurious_q;

endmodule
